// File: rtl/alu_seq_pkg.sv
// Shared ALU op codes, execute-unit FSM states and op-class helper.
// Used by alu_seq and alu_seq_comb; also consumed by the ALU control decoder.
package alu_seq_pkg;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SLL = 4'b0100,
        ALU_SRL = 4'b0101,
        ALU_SRA = 4'b0111,
        ALU_EQ  = 4'b1000,
        ALU_SLT = 4'b1100
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } alu_seq_state_e;

    function automatic logic is_shift(input alu_op_e op);
        return op inside {ALU_SLL, ALU_SRL, ALU_SRA};
    endfunction

endpackage

// File: rtl/alu_seq_comb.sv
// Single-cycle ALU ops and illegal-op detection for alu_seq.
// With ALU_SEQ_BARREL_EN defined, shifts are done here by a barrel shifter.
module alu_seq_comb
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic [WIDTH-1:0] result,
    output logic             illegal
);

`ifdef ALU_SEQ_BARREL_EN
    localparam int SHW = $clog2(WIDTH);
`endif

    always_comb begin
        result  = '0;
        illegal = 1'b0;
        case (alu_op_e'(op))
            ALU_AND: result = src_a & src_b;
            ALU_OR:  result = src_a | src_b;
            ALU_ADD: result = src_a + src_b;
            ALU_EQ:  result = {{(WIDTH-1){1'b0}}, (src_a == src_b)};
            ALU_SLT: result = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
`ifdef ALU_SEQ_BARREL_EN
            ALU_SLL: result = src_a << src_b[SHW-1:0];
            ALU_SRL: result = src_a >> src_b[SHW-1:0];
            ALU_SRA: result = $unsigned($signed(src_a) >>> src_b[SHW-1:0]);
`else
            // Only reached for a zero shift amount; longer shifts iterate in the top.
            ALU_SLL, ALU_SRL, ALU_SRA: result = src_a;
`endif
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle EX-stage ALU: valid/ready handshake, one-bit-per-cycle shifts.
// Define ALU_SEQ_BARREL_EN for single-cycle barrel shifts (no SHIFT state).
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);

    alu_seq_state_e   state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             illegal_q, illegal_d;
    logic [WIDTH-1:0] comb_result;
    logic             comb_illegal;
    logic             start_shift;

`ifndef ALU_SEQ_BARREL_EN
    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH-1:0] work_q, work_d, work_step;
    logic [SHW-1:0]   cnt_q, cnt_d;
    alu_op_e          op_q, op_d;
`endif

    alu_seq_comb #(
        .WIDTH(WIDTH)
    ) u_comb (
        .op      (op),
        .src_a   (src_a),
        .src_b   (src_b),
        .result  (comb_result),
        .illegal (comb_illegal)
    );

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;

`ifndef ALU_SEQ_BARREL_EN
    assign start_shift = is_shift(alu_op_e'(op)) && (src_b[SHW-1:0] != '0);

    always_comb begin
        case (op_q)
            ALU_SLL: work_step = {work_q[WIDTH-2:0], 1'b0};
            ALU_SRL: work_step = {1'b0, work_q[WIDTH-1:1]};
            ALU_SRA: work_step = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
            default: work_step = work_q;
        endcase
    end
`else
    assign start_shift = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
`ifndef ALU_SEQ_BARREL_EN
        work_d    = work_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid && !flush) begin
`ifndef ALU_SEQ_BARREL_EN
                    work_d = src_a;
                    cnt_d  = src_b[SHW-1:0];
                    op_d   = alu_op_e'(op);
`endif
                    if (start_shift) begin
                        state_d = SHIFT;
                    end else begin
                        state_d   = DONE;
                        result_d  = comb_result;
                        zero_d    = (comb_result == '0);
                        illegal_d = comb_illegal;
                    end
                end
            end
`ifndef ALU_SEQ_BARREL_EN
            SHIFT: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    work_d = work_step;
                    cnt_d  = cnt_q - SHW'(1);
                    if (cnt_q == SHW'(1)) begin
                        state_d   = DONE;
                        result_d  = work_step;
                        zero_d    = (work_step == '0);
                        illegal_d = 1'b0;
                    end
                end
            end
`endif
            DONE: begin
                if (flush || out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            result_q  <= '0;
            zero_q    <= 1'b1;
            illegal_q <= 1'b0;
`ifndef ALU_SEQ_BARREL_EN
            work_q    <= '0;
            cnt_q     <= '0;
            op_q      <= ALU_AND;
`endif
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
`ifndef ALU_SEQ_BARREL_EN
            work_q    <= work_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
`endif
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Randomised self-checking bench for alu_seq against a behavioural op model.
// Expected latency follows ALU_SEQ_BARREL_EN when the bench is built with it.
module tb_alu_seq;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset, flush, in_valid, out_ready;
    logic             in_ready, out_valid, zero, illegal;
    logic [3:0]       op;
    logic [WIDTH-1:0] src_a, src_b, result;

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0] legal_ops [8] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100,
                                  4'b0101, 4'b0111, 4'b1000, 4'b1100};

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .src_a     (src_a),
        .src_b     (src_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .illegal   (illegal)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic ref_legal(input logic [3:0] o);
        return o inside {4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0101, 4'b0111, 4'b1000, 4'b1100};
    endfunction

    function automatic logic [WIDTH-1:0] ref_result(input logic [3:0] o, input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b);
        int unsigned sh = b % WIDTH;
        case (o)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0100: return a << sh;
            4'b0101: return a >> sh;
            4'b0111: return $unsigned($signed(a) >>> sh);
            4'b1000: return (a == b) ? WIDTH'(1) : WIDTH'(0);
            4'b1100: return ($signed(a) < $signed(b)) ? WIDTH'(1) : WIDTH'(0);
            default: return '0;
        endcase
    endfunction

    function automatic int ref_latency(input logic [3:0] o, input logic [WIDTH-1:0] b);
`ifdef ALU_SEQ_BARREL_EN
        return 1;
`else
        int sh = int'(b % WIDTH);
        if (o inside {4'b0100, 4'b0101, 4'b0111}) return 1 + sh;
        return 1;
`endif
    endfunction

    // One full transaction: accept, wait for result, hold in DONE, hand off.
    task automatic run_op(input string tag, input logic [3:0] o, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input int hold);
        logic [WIDTH-1:0] er;
        int               el, lat;
        logic             busy_ok, hold_ok;
        er = ref_result(o, a, b);
        el = ref_latency(o, b);
        @(negedge clk);
        check({tag, ":in_ready"}, in_ready, 1);
        op = o; src_a = a; src_b = b; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        lat = 1;
        busy_ok = 1'b1;
        while (!out_valid && lat < 40) begin
            if (in_ready) busy_ok = 1'b0;
            in_valid = 1'($urandom); op = 4'($urandom); src_a = $urandom; src_b = $urandom;
            @(posedge clk); #1;
            lat++;
        end
        if (in_ready) busy_ok = 1'b0;
        check({tag, ":latency"}, lat, el);
        check({tag, ":busy_in_ready_low"}, busy_ok, 1);
        check({tag, ":result"}, result, er);
        check({tag, ":zero"}, zero, (er == '0));
        check({tag, ":illegal"}, illegal, !ref_legal(o));
        hold_ok = 1'b1;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom); op = 4'($urandom); src_a = $urandom; src_b = $urandom;
            @(posedge clk); #1;
            if (!out_valid || result !== er || zero !== (er == '0)) hold_ok = 1'b0;
        end
        if (hold > 0) check({tag, ":hold_stable"}, hold_ok, 1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b0;
        check({tag, ":handoff_out_valid"}, out_valid, 0);
        check({tag, ":handoff_in_ready"}, in_ready, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic ok;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = '0; src_a = '0; src_b = '0;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_zero", zero, 1);
        check("rst_illegal", illegal, 0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;

        run_op("add_ovf",  4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 0);
        run_op("add_wrap", 4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 0);
        run_op("sra31",    4'b0111, 32'h8000_0000, 32'd31, 0);
        run_op("srl31",    4'b0101, 32'h8000_0000, 32'd31, 0);
        run_op("sll_sh0",  4'b0100, 32'h0000_0001, 32'h0000_0020, 0);
        run_op("slt_neg",  4'b1100, 32'hFFFF_FFFF, 32'h0000_0001, 0);
        run_op("eq_same",  4'b1000, 32'd5, 32'd5, 0);
        run_op("illegal3", 4'b0011, 32'h1234_5678, 32'h9ABC_DEF0, 0);
        run_op("hold5",    4'b0001, 32'hA5A5_0000, 32'h0000_5A5A, 5);

        // flush on the third SHIFT cycle of a shift by 10
        @(negedge clk);
        op = 4'b0100; src_a = 32'h1; src_b = 32'd10; in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_shift_out_valid", out_valid, 0);
        check("flush_shift_in_ready", in_ready, 1);
        ok = 1'b1;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid) ok = 1'b0;
        end
        check("flush_shift_no_result", ok, 1);

        // flush in IDLE blocks the accept
        @(negedge clk);
        op = 4'b0010; src_a = 32'd1; src_b = 32'd2; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        check("flush_idle_in_ready", in_ready, 1);
        check("flush_idle_out_valid", out_valid, 0);

        // flush in DONE discards the result
        @(negedge clk);
        op = 4'b0010; src_a = 32'd3; src_b = 32'd4; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("flush_done_out_valid_pre", out_valid, 1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_done_out_valid", out_valid, 0);
        check("flush_done_in_ready", in_ready, 1);

        // asynchronous reset in the middle of a shift
        run_op("pre_reset", 4'b0010, 32'h10, 32'h20, 0);
        @(negedge clk);
        op = 4'b0111; src_a = 32'h8000_0000; src_b = 32'd20; in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_result", result, 0);
        check("midrst_zero", zero, 1);
        check("midrst_illegal", illegal, 0);
        @(negedge clk);
        reset = 1'b0;

        for (int n = 0; n < 200; n++) begin
            logic [3:0] o;
            if ($urandom_range(0, 3) == 0) o = 4'($urandom);
            else o = legal_ops[$urandom_range(0, 7)];
            run_op("rand", o, $urandom, $urandom, int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
